sa_wr_dma_arbiter: RTL and testbench

- Shares one dma_write engine between NUM_REQ output producers, e.g. systolic-array output tile drainers or a bias/result writer.
- Accepts write jobs (base address, byte length) from each requester and grants them round-robin.
- For the granted job: issues the engine start pulse, routes that requester's data stream into the engine, and returns per-requester done/error.
- Sits between the SA output buffers and the dma_write control/stream ports.

---
 rtl/sa_wr_dma_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sa_wr_dma_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wr_dma_arbiter.sv
// sa_wr_dma_arbiter: shares one dma_write engine between NUM_REQ producers.
// Jobs (base address, byte length) are granted round-robin, length-checked,
// started on the engine, and the granted requester's stream is routed
// through until the engine reports done.
// Optional feature macro: SA_WR_ARB_STATS_EN adds per-requester job counters
// (o_job_cnt) and a saturating error-job counter (o_err_cnt).
module sa_wr_dma_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned OUT_BITS_TRANS = 13
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*32-1:0]     i_req_addr,
    input  logic [NUM_REQ*32-1:0]     i_req_len,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_dvalid,
    output logic [NUM_REQ-1:0]        o_req_dready,
    output logic [NUM_REQ-1:0]        o_req_done,
    output logic [NUM_REQ-1:0]        o_req_error,
    output logic                      o_dma_start,
    output logic [31:0]               o_dma_base_addr,
    output logic [31:0]               o_dma_byte_len,
    input  logic                      i_dma_busy,
    input  logic                      i_dma_done,
    input  logic                      i_dma_error,
    output logic [DATA_W-1:0]         o_dma_data,
    output logic                      o_dma_valid,
    input  logic                      i_dma_ready,
    output logic                      o_busy
`ifdef SA_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     o_job_cnt,
    output logic [15:0]               o_err_cnt
`endif
);

    localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CandW = IdxW + 1;
    // Largest legal job in 32-bit words.
    localparam logic [29:0] MaxWords = 30'((64'd1 << OUT_BITS_TRANS) - 64'd1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StStart,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       len_q, len_d;
    logic              err_q, err_d;

    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [CandW-1:0]  cand;
    logic              len_ok;
    logic              route;

    // Engine busy is status only; the FSM tracks the job from start to done.
    logic              unused_dma_busy;
    assign unused_dma_busy = i_dma_busy;

    // Round-robin pick: first valid requester at or after rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + CandW'(k);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!pick_found && i_req_valid[IdxW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    assign len_ok = (len_q[1:0] == 2'b00) && (len_q[31:2] <= MaxWords);

    // Next-state and latched job fields.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = i_req_addr[int'(pick_idx)*32 +: 32];
                    len_d   = i_req_len[int'(pick_idx)*32 +: 32];
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!len_ok) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                if (i_dma_error) begin
                    err_d = 1'b1;
                end
                if (i_dma_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                rr_d    = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and job registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign route = (state_q == StStart) || (state_q == StRun);

    // Grant pulse, stream routing and completion outputs.
    always_comb begin
        o_req_ready  = '0;
        o_req_dready = '0;
        o_req_done   = '0;
        o_req_error  = '0;
        o_dma_data   = '0;
        o_dma_valid  = 1'b0;
        // Gated by reset so no grant escapes while reset is held.
        if ((state_q == StIdle) && pick_found && ARESETN) begin
            o_req_ready[pick_idx] = 1'b1;
        end
        if (route) begin
            o_dma_data            = i_req_data[int'(grant_q)*DATA_W +: DATA_W];
            o_dma_valid           = i_req_dvalid[grant_q];
            o_req_dready[grant_q] = i_dma_ready;
        end
        if (state_q == StDone) begin
            o_req_done[grant_q]  = 1'b1;
            o_req_error[grant_q] = err_q;
        end
    end

    assign o_dma_start     = (state_q == StStart);
    assign o_dma_base_addr = addr_q;
    assign o_dma_byte_len  = len_q;
    assign o_busy          = (state_q != StIdle);

`ifdef SA_WR_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] job_cnt_q;
    logic [15:0]           err_cnt_q;

    // Completed-job counters: per requester wrapping, error total saturating.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            job_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (state_q == StDone) begin
            job_cnt_q[int'(grant_q)*16 +: 16] <= job_cnt_q[int'(grant_q)*16 +: 16] + 16'd1;
            if (err_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_job_cnt = job_cnt_q;
    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sa_wr_dma_arbiter.sv
// Directed bench for sa_wr_dma_arbiter (default build, 4 requesters).
module tb_sa_wr_dma_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              ACLK;
    logic              ARESETN;
    logic [NR-1:0]     i_req_valid;
    logic [NR*32-1:0]  i_req_addr;
    logic [NR*32-1:0]  i_req_len;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  i_req_data;
    logic [NR-1:0]     i_req_dvalid;
    logic [NR-1:0]     o_req_dready;
    logic [NR-1:0]     o_req_done;
    logic [NR-1:0]     o_req_error;
    logic              o_dma_start;
    logic [31:0]       o_dma_base_addr;
    logic [31:0]       o_dma_byte_len;
    logic              i_dma_busy;
    logic              i_dma_done;
    logic              i_dma_error;
    logic [DW-1:0]     o_dma_data;
    logic              o_dma_valid;
    logic              i_dma_ready;
    logic              o_busy;

    int nvec;
    int nmiss;
    int nstart;

    sa_wr_dma_arbiter #(
        .NUM_REQ(NR),
        .DATA_W(DW),
        .OUT_BITS_TRANS(13)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .i_req_valid(i_req_valid),
        .i_req_addr(i_req_addr),
        .i_req_len(i_req_len),
        .o_req_ready(o_req_ready),
        .i_req_data(i_req_data),
        .i_req_dvalid(i_req_dvalid),
        .o_req_dready(o_req_dready),
        .o_req_done(o_req_done),
        .o_req_error(o_req_error),
        .o_dma_start(o_dma_start),
        .o_dma_base_addr(o_dma_base_addr),
        .o_dma_byte_len(o_dma_byte_len),
        .i_dma_busy(i_dma_busy),
        .i_dma_done(i_dma_done),
        .i_dma_error(i_dma_error),
        .o_dma_data(o_dma_data),
        .o_dma_valid(o_dma_valid),
        .i_dma_ready(i_dma_ready),
        .o_busy(o_busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Engine start pulses, sampled away from the active edge.
    always @(negedge ACLK) begin
        if (o_dma_start === 1'b1) nstart++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmiss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int g, input logic [31:0] a, input logic [31:0] l);
        i_req_addr[g*32 +: 32] = a;
        i_req_len[g*32 +: 32]  = l;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        settle();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        settle();
    endtask

    // Legal job from IDLE. mode: 0 clean, 1 error pulse in RUN, 2 error with done,
    // 3 error pulse during START (must be ignored).
    task automatic legal_job(input int g, input logic [31:0] a, input logic [31:0] l,
                             input int mode, input bit keep);
        logic [NR-1:0] onehot;
        logic [NR-1:0] experr;
        onehot = NR'(1 << g);
        experr = (mode == 1 || mode == 2) ? onehot : '0;
        settle();
        chk("grant", o_req_ready, onehot);
        tick();
        if (!keep) i_req_valid[g] = 1'b0;
        settle();
        chk("check_no_start", o_dma_start, 1'b0);
        chk("check_no_regrant", o_req_ready, '0);
        tick();
        chk("start", o_dma_start, 1'b1);
        chk("start_addr", o_dma_base_addr, a);
        chk("start_len", o_dma_byte_len, l);
        if (mode == 3) i_dma_error = 1'b1;
        tick();
        i_dma_error = 1'b0;
        settle();
        chk("run_no_start", o_dma_start, 1'b0);
        if (mode == 1) begin
            i_dma_error = 1'b1;
            tick();
            i_dma_error = 1'b0;
        end
        i_dma_done = 1'b1;
        if (mode == 2) i_dma_error = 1'b1;
        settle();
        chk("no_done_in_run", o_req_done, '0);
        tick();
        i_dma_done  = 1'b0;
        i_dma_error = 1'b0;
        settle();
        chk("done", o_req_done, onehot);
        chk("done_err", o_req_error, experr);
        tick();
        chk("back_idle", o_busy, 1'b0);
    endtask

    // Illegal job from IDLE: no start, done with error two cycles after grant.
    task automatic illegal_job(input int g);
        logic [NR-1:0] onehot;
        onehot = NR'(1 << g);
        settle();
        chk("ill_grant", o_req_ready, onehot);
        tick();
        i_req_valid[g] = 1'b0;
        settle();
        chk("ill_check_no_start", o_dma_start, 1'b0);
        chk("ill_busy", o_busy, 1'b1);
        tick();
        chk("ill_no_start", o_dma_start, 1'b0);
        chk("ill_done", o_req_done, onehot);
        chk("ill_err", o_req_error, onehot);
        tick();
        chk("ill_idle", o_busy, 1'b0);
    endtask

    initial begin
        int base;
        nvec = 0; nmiss = 0; nstart = 0;
        ARESETN = 1'b0;
        i_req_valid = '0; i_req_addr = '0; i_req_len = '0;
        i_req_data = '0; i_req_dvalid = '0;
        i_dma_busy = 1'b0; i_dma_done = 1'b0; i_dma_error = 1'b0; i_dma_ready = 1'b0;
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_start", o_dma_start, 1'b0);
        chk("rst_addr", o_dma_base_addr, 32'h0);
        chk("rst_len", o_dma_byte_len, 32'h0);
        chk("rst_done", o_req_done, '0);
        i_req_valid = 4'hF;
        settle();
        chk("rst_ready_gated", o_req_ready, '0);
        i_req_valid = '0;
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        settle();

        // Single job on requester 1 with stream routing and isolation.
        i_req_valid = 4'b0010;
        set_req(1, 32'h1000_0000, 32'd64);
        settle();
        chk("t1_grant", o_req_ready, 4'b0010);
        tick();
        i_req_valid = '0;
        settle();
        chk("t1_busy", o_busy, 1'b1);
        chk("t1_no_start", o_dma_start, 1'b0);
        tick();
        chk("t1_start", o_dma_start, 1'b1);
        chk("t1_addr", o_dma_base_addr, 32'h1000_0000);
        chk("t1_len", o_dma_byte_len, 32'd64);
        i_req_data[0*DW +: DW] = 32'hDEAD;
        i_req_data[1*DW +: DW] = 32'h100;
        i_req_dvalid = 4'b0011;
        i_dma_ready = 1'b1;
        settle();
        chk("t1_data0", o_dma_data, 32'h100);
        chk("t1_valid0", o_dma_valid, 1'b1);
        chk("t1_dready0", o_req_dready, 4'b0010);
        tick();
        chk("t1_run_no_start", o_dma_start, 1'b0);
        for (int w = 1; w < 16; w++) begin
            i_req_data[1*DW +: DW] = 32'h100 + 32'(w);
            i_req_dvalid[1] = (w % 3) != 0;
            i_req_dvalid[0] = (w % 2) != 0;
            i_dma_ready = (w % 4) != 0;
            settle();
            chk("t1_data", o_dma_data, 32'h100 + 32'(w));
            chk("t1_valid", o_dma_valid, (w % 3) != 0);
            chk("t1_dready", o_req_dready, ((w % 4) != 0) ? 4'b0010 : 4'b0000);
            tick();
        end
        i_dma_done = 1'b1;
        i_req_dvalid = '0;
        i_dma_ready = 1'b0;
        settle();
        chk("t1_no_done_yet", o_req_done, '0);
        tick();
        i_dma_done = 1'b0;
        settle();
        chk("t1_done", o_req_done, 4'b0010);
        chk("t1_err", o_req_error, 4'b0000);
        chk("t1_done_valid", o_dma_valid, 1'b0);
        chk("t1_done_data", o_dma_data, 32'h0);
        tick();
        chk("t1_idle", o_busy, 1'b0);

        // Round robin with all requesters held valid from reset.
        do_reset();
        for (int g = 0; g < NR; g++) set_req(g, 32'h2000_0000 + 32'(g * 256), 32'd16);
        i_req_valid = 4'hF;
        base = nstart;
        legal_job(0, 32'h2000_0000, 32'd16, 0, 1'b1);
        legal_job(1, 32'h2000_0100, 32'd16, 0, 1'b1);
        legal_job(2, 32'h2000_0200, 32'd16, 0, 1'b1);
        legal_job(3, 32'h2000_0300, 32'd16, 0, 1'b1);
        legal_job(0, 32'h2000_0000, 32'd16, 0, 1'b1);
        i_req_valid = '0;
        chk("rr_start_count", 64'(nstart - base), 64'd5);

        // Length checks on requester 2.
        base = nstart;
        set_req(2, 32'h3000, 32'd18);
        i_req_valid = 4'b0100;
        illegal_job(2);
        set_req(2, 32'h3000, 32'h0004_0000);
        i_req_valid = 4'b0100;
        illegal_job(2);
        set_req(2, 32'h3000, 32'h0000_8000);
        i_req_valid = 4'b0100;
        illegal_job(2);
        chk("ill_start_count", 64'(nstart - base), 64'd0);
        set_req(2, 32'h3000, 32'd32764);
        i_req_valid = 4'b0100;
        legal_job(2, 32'h3000, 32'd32764, 0, 1'b0);
        set_req(2, 32'h3100, 32'd0);
        i_req_valid = 4'b0100;
        legal_job(2, 32'h3100, 32'd0, 0, 1'b0);

        // Engine error reporting and sticky clear; done/error ignored in IDLE.
        i_dma_done = 1'b1;
        i_dma_error = 1'b1;
        tick();
        i_dma_done = 1'b0;
        i_dma_error = 1'b0;
        settle();
        chk("idle_done_ignored", o_req_done, '0);
        chk("idle_stays", o_busy, 1'b0);
        set_req(0, 32'h4000, 32'd16);
        i_req_valid = 4'b0001;
        legal_job(0, 32'h4000, 32'd16, 1, 1'b0);
        i_req_valid = 4'b0001;
        legal_job(0, 32'h4000, 32'd16, 3, 1'b0);
        i_req_valid = 4'b0001;
        legal_job(0, 32'h4000, 32'd16, 2, 1'b0);
        i_req_valid = 4'b0001;
        legal_job(0, 32'h4000, 32'd16, 0, 1'b0);

        // Reset in the middle of RUN.
        for (int g = 0; g < NR; g++) set_req(g, 32'h5000_0000 + 32'(g * 16), 32'd16);
        i_req_valid = 4'b1111;
        settle();
        chk("mr_grant", o_req_ready, 4'b0010);
        tick();
        tick();
        chk("mr_start", o_dma_start, 1'b1);
        tick();
        i_dma_ready = 1'b1;
        i_req_dvalid = 4'hF;
        settle();
        chk("mr_run_dready", o_req_dready, 4'b0010);
        ARESETN = 1'b0;
        settle();
        chk("mr_busy", o_busy, 1'b0);
        chk("mr_ready", o_req_ready, '0);
        chk("mr_dready", o_req_dready, '0);
        chk("mr_valid", o_dma_valid, 1'b0);
        chk("mr_data", o_dma_data, 32'h0);
        chk("mr_addr", o_dma_base_addr, 32'h0);
        chk("mr_len", o_dma_byte_len, 32'h0);
        chk("mr_done", o_req_done, '0);
        tick();
        i_dma_ready = 1'b0;
        i_req_dvalid = '0;
        ARESETN = 1'b1;
        i_req_valid = 4'b0110;
        legal_job(1, 32'h5000_0010, 32'd16, 0, 1'b0);
        i_req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
